// File: rtl/pipe_ctrl_if.sv
// Stall/flush sequencer bus: hazard, branch and memory status in, per-stage register controls and stats out.
// master drives the status side; slave is the sequencer.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hdu_ifid_en;
  logic             hdu_mux_ctrl;
  logic             fetch_en;
  logic             imem_ready;
  logic             br_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_en;
  logic             memwb_bubble;
  logic             dmem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hdu_ifid_en, hdu_mux_ctrl, fetch_en, imem_ready, br_taken, dmem_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, memwb_bubble,
    input  dmem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  hdu_ifid_en, hdu_mux_ctrl, fetch_en, imem_ready, br_taken, dmem_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, memwb_bubble,
    output dmem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer with data-memory wait FSM, timeout trap and saturating stats.
// Latency: stage controls are combinational (zero cycles); FSM, error flag and counters registered.
// Backpressure: a pending data-memory access freezes PC..EX/MEM and bubbles MEM/WB until ready.
module pipe_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_ERR
  } state_t;

  state_t           state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic             err_q, err_set;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, memwb_bubble;
  logic use_rules, freeze, br_fire;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_set   = 1'b0;
    use_rules = 1'b0;
    freeze    = 1'b0;

    if (!rst) begin
      unique case (state)
        S_RUN: begin
          if (bus.dmem_req && !bus.dmem_ready) begin
            freeze    = 1'b1;
            state_nxt = S_WAIT;
            wait_nxt  = WAIT_W'(1);
          end else begin
            use_rules = 1'b1;
          end
        end
        S_WAIT: begin
          if (!bus.dmem_ready) begin
            freeze = 1'b1;
            if (wait_cnt == WAIT_W'(TIMEOUT)) begin
              state_nxt = S_ERR;
              err_set   = 1'b1;
            end else begin
              wait_nxt = wait_cnt + WAIT_W'(1);
            end
          end else begin
            // Release cycle: the stalled MEM access retires, remaining hazards apply normally.
            use_rules = 1'b1;
            state_nxt = S_RUN;
            wait_nxt  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    memwb_bubble = 1'b0;
    br_fire      = 1'b0;

    if (freeze) begin
      memwb_en     = 1'b1;
      memwb_bubble = 1'b1;
    end else if (use_rules) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      // A taken branch squashes the stalled instruction anyway, so it wins over hazards.
      if (bus.br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        br_fire     = 1'b1;
      end else if (!bus.hdu_ifid_en || !bus.hdu_mux_ctrl) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end else if (!bus.fetch_en || !bus.imem_ready) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_q | err_set;
      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (br_fire && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_en      = idex_en;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_en     = memwb_en;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.dmem_err     = err_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (CNT_W=2, TIMEOUT=4): vectors push expectations, a negedge monitor checks.
module tb_pipe_ctrl;
  // Input vector bits: {rst, hdu_ifid_en, hdu_mux_ctrl, fetch_en, imem_ready, br_taken, dmem_req, dmem_ready}
  localparam logic [7:0] I_RST    = 8'b11111000;
  localparam logic [7:0] I_RSTW   = 8'b11111010;
  localparam logic [7:0] I_IDLE   = 8'b01111000;
  localparam logic [7:0] I_HAZ    = 8'b00011000;
  localparam logic [7:0] I_HAZ1   = 8'b00111000;
  localparam logic [7:0] I_BRHAZ  = 8'b00111100;
  localparam logic [7:0] I_BR     = 8'b01111100;
  localparam logic [7:0] I_IMEM0  = 8'b01110000;
  localparam logic [7:0] I_FETEN0 = 8'b01101000;
  localparam logic [7:0] I_HAZIM  = 8'b00010000;
  localparam logic [7:0] I_DWAIT  = 8'b01111010;
  localparam logic [7:0] I_DWBR   = 8'b01111110;
  localparam logic [7:0] I_DDONE  = 8'b01111011;
  localparam logic [7:0] I_DRELBR = 8'b01111111;

  // Control bits: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, memwb_bubble}
  localparam logic [7:0] C_OFF = 8'b00000000;
  localparam logic [7:0] C_ADV = 8'b11010110;
  localparam logic [7:0] C_FRZ = 8'b00000011;
  localparam logic [7:0] C_BR  = 8'b11111110;
  localparam logic [7:0] C_HAZ = 8'b00011110;
  localparam logic [7:0] C_FET = 8'b01110110;

  typedef struct packed {
    logic [7:0] ctrl;
    logic       err;
    logic [1:0] stall;
    logic [1:0] flush;
  } exp_t;

  logic clk;
  logic rst;
  pipe_ctrl_if #(.CNT_W(2)) bus ();

  pipe_ctrl #(.CNT_W(2), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   vec_idx = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic [7:0] v);
    {rst, bus.hdu_ifid_en, bus.hdu_mux_ctrl, bus.fetch_en, bus.imem_ready,
     bus.br_taken, bus.dmem_req, bus.dmem_ready} = v;
  endtask

  task automatic step(input logic [7:0] v, input logic [7:0] c, input logic e,
                      input logic [1:0] st, input logic [1:0] fl);
    @(posedge clk);
    #1;
    apply(v);
    exp_q.push_back({c, e, st, fl});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t got;
      e   = exp_q.pop_front();
      got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_bubble,
             bus.exmem_en, bus.memwb_en, bus.memwb_bubble, bus.dmem_err,
             bus.stall_cnt, bus.flush_cnt};
      checks++;
      if (got === e) begin
        passed++;
      end else begin
        $display("FAIL vec%0d: ctrl=%b err=%b stall=%0d flush=%0d, expected ctrl=%b err=%b stall=%0d flush=%0d",
                 vec_idx, got.ctrl, got.err, got.stall, got.flush, e.ctrl, e.err, e.stall, e.flush);
      end
      vec_idx++;
    end
  end

  initial begin
    apply(I_RST);
    // Reset and load-use stall
    step(I_RST,   C_OFF, 1'b0, 2'd0, 2'd0);
    step(I_IDLE,  C_ADV, 1'b0, 2'd0, 2'd0);
    step(I_HAZ,   C_HAZ, 1'b0, 2'd0, 2'd0);
    step(I_IDLE,  C_ADV, 1'b0, 2'd1, 2'd0);
    // Branch beats hazard
    step(I_BRHAZ, C_BR,  1'b0, 2'd1, 2'd0);
    step(I_IDLE,  C_ADV, 1'b0, 2'd1, 2'd1);
    // Three-cycle data-memory wait; dmem freeze beats branch
    step(I_RST,   C_OFF, 1'b0, 2'd1, 2'd1);
    step(I_IDLE,  C_ADV, 1'b0, 2'd0, 2'd0);
    step(I_DWBR,  C_FRZ, 1'b0, 2'd0, 2'd0);
    step(I_DWAIT, C_FRZ, 1'b0, 2'd1, 2'd0);
    step(I_DWAIT, C_FRZ, 1'b0, 2'd2, 2'd0);
    step(I_DDONE, C_ADV, 1'b0, 2'd3, 2'd0);
    step(I_IDLE,  C_ADV, 1'b0, 2'd3, 2'd0);
    // Branch held through the wait is honoured at release
    step(I_RST,    C_OFF, 1'b0, 2'd3, 2'd0);
    step(I_IDLE,   C_ADV, 1'b0, 2'd0, 2'd0);
    step(I_DWAIT,  C_FRZ, 1'b0, 2'd0, 2'd0);
    step(I_DRELBR, C_BR,  1'b0, 2'd1, 2'd0);
    step(I_IDLE,   C_ADV, 1'b0, 2'd1, 2'd1);
    // Timeout into ERROR, then recovery through reset
    step(I_RST,   C_OFF, 1'b0, 2'd1, 2'd1);
    step(I_IDLE,  C_ADV, 1'b0, 2'd0, 2'd0);
    step(I_DWAIT, C_FRZ, 1'b0, 2'd0, 2'd0);
    step(I_DWAIT, C_FRZ, 1'b0, 2'd1, 2'd0);
    step(I_DWAIT, C_FRZ, 1'b0, 2'd2, 2'd0);
    step(I_DWAIT, C_FRZ, 1'b0, 2'd3, 2'd0);
    step(I_DWAIT, C_FRZ, 1'b0, 2'd3, 2'd0);
    step(I_DWAIT, C_OFF, 1'b1, 2'd3, 2'd0);
    step(I_DDONE, C_OFF, 1'b1, 2'd3, 2'd0);
    step(I_BR,    C_OFF, 1'b1, 2'd3, 2'd0);
    step(I_RST,   C_OFF, 1'b1, 2'd3, 2'd0);
    step(I_IDLE,  C_ADV, 1'b0, 2'd0, 2'd0);
    // Fetch stalls; hazard beats fetch stall
    step(I_IMEM0,  C_FET, 1'b0, 2'd0, 2'd0);
    step(I_IMEM0,  C_FET, 1'b0, 2'd1, 2'd0);
    step(I_FETEN0, C_FET, 1'b0, 2'd2, 2'd0);
    step(I_HAZIM,  C_HAZ, 1'b0, 2'd3, 2'd0);
    step(I_IDLE,   C_ADV, 1'b0, 2'd3, 2'd0);
    // Counter saturation
    step(I_RST,   C_OFF, 1'b0, 2'd3, 2'd0);
    step(I_IDLE,  C_ADV, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 6; i++) begin
      step(I_HAZ1, C_HAZ, 1'b0, (i > 3) ? 2'd3 : 2'(i), 2'd0);
    end
    step(I_IDLE,  C_ADV, 1'b0, 2'd3, 2'd0);
    for (int i = 0; i < 5; i++) begin
      step(I_BR, C_BR, 1'b0, 2'd3, (i > 3) ? 2'd3 : 2'(i));
    end
    step(I_IDLE,  C_ADV, 1'b0, 2'd3, 2'd3);
    // Reset in the middle of a wait
    step(I_DWAIT, C_FRZ, 1'b0, 2'd3, 2'd3);
    step(I_DWAIT, C_FRZ, 1'b0, 2'd3, 2'd3);
    step(I_RSTW,  C_OFF, 1'b0, 2'd3, 2'd3);
    step(I_IDLE,  C_ADV, 1'b0, 2'd0, 2'd0);
    step(I_DWAIT, C_FRZ, 1'b0, 2'd0, 2'd0);
    step(I_DDONE, C_ADV, 1'b0, 2'd1, 2'd0);
    step(I_IDLE,  C_ADV, 1'b0, 2'd1, 2'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer. It consumes the hazard unit's stall request (IFID_enable/muxControl pair), the branch-resolution signal from EX and the instruction/data-memory ready handshakes. It produces per-stage load enables and bubble/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. A small FSM freezes the pipeline across multi-cycle data-memory accesses, detects memory timeouts and keeps saturating stall and flush statistics.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt
TIMEOUT, 64, max DMEM_WAIT cycles before error; wait counter width = $clog2(TIMEOUT+1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
hdu_ifid_en  in  1  hazard unit IF/ID enable; 0 = load-use stall
hdu_mux_ctrl  in  1  hazard unit control-word select; 0 = insert bubble
fetch_en  in  1  CU fetch enable
imem_ready  in  1  instruction memory has valid data this cycle
br_taken  in  1  EX-stage branch/jump resolved taken (redirect)
dmem_req  in  1  MEM-stage instruction is a load/store accessing memory this cycle
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP (valid only when ifid_en=1)
idex_en  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX loads zero control word
exmem_en  out  1  EX/MEM load enable
memwb_en  out  1  MEM/WB load enable
memwb_bubble  out  1  MEM/WB loads NOP
dmem_err  out  1  sticky data-memory timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0
flush_cnt  out  CNT_W  saturating count of taken-branch flush cycles

Behaviour:
- Enables and bubble/flush outputs are combinational from current state and inputs, with zero latency. State, wait counter, dmem_err and statistics are registered.
- Reset (rst=1 at an edge): state=RUN, wait_cnt=0, dmem_err=0, stall_cnt=0, flush_cnt=0. While rst is high, all enables=0 and all flush/bubble outputs=0. Reset asserted mid-wait aborts the wait immediately.
- "Advance" default: all enables=1, all flush/bubble=0.
- RUN, evaluated in priority order:
  1. dmem_req=1 and dmem_ready=0: freeze. pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, memwb_bubble=1. Next state=DMEM_WAIT, wait_cnt=1.
  2. br_taken=1: advance with ifid_flush=1 and idex_bubble=1. Branch overrides any hazard stall.
  3. hdu_ifid_en=0 or hdu_mux_ctrl=0: pc_en=0, ifid_en=0, idex_bubble=1, rest advance.
  4. fetch_en=0 or imem_ready=0: pc_en=0, ifid_flush=1, rest advance.
  5. Otherwise: advance.
- DMEM_WAIT:
  - dmem_ready=0: freeze outputs as in RUN rule 1. wait_cnt increments.
  - If wait_cnt==TIMEOUT and dmem_ready=0: next=ERROR, dmem_err=1.
  - dmem_ready=1: apply RUN rules 2-5 this cycle (dmem rule skipped). Next=RUN, wait_cnt=0.
  - br_taken held during the wait is honoured in the release cycle.
- ERROR: all enables=0, all flush/bubble=0, dmem_err=1. Leaves only via rst.
- stall_cnt increments each non-reset cycle with pc_en=0, including ERROR. flush_cnt increments each cycle RUN rule 2 fires. Both saturate at 2^CNT_W-1 and do not wrap.

Test Plan:
- Load-use: hdu_ifid_en=0 and hdu_mux_ctrl=0 for 1 cycle in RUN -> pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1; stall_cnt 0->1.
- Branch plus hazard same cycle: br_taken=1, hdu_ifid_en=0 -> pc_en=1, ifid_flush=1, idex_bubble=1; flush_cnt=1, stall_cnt unchanged.
- DMEM wait of 3 cycles: dmem_req=1, dmem_ready low for 3 cycles then high -> 3 cycles with pc_en=0 and memwb_bubble=1. Release cycle: all enables=1, state RUN, stall_cnt=3.
- Timeout: TIMEOUT=4, dmem_ready never asserted -> dmem_err=1 after 4th wait cycle. Enables stay 0. rst clears dmem_err and state=RUN.
- Fetch stall: imem_ready=0 for 2 cycles -> pc_en=0, ifid_flush=1, idex_en=1 both cycles.
- Saturation: CNT_W=2, hold hazard stall 6 cycles -> stall_cnt sticks at 3. Reset mid-DMEM_WAIT -> next cycle RUN, counters 0.
